// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator keypad/display path.
//   state_t      : keypad encoder scan/debounce states
//   KEY_*        : key codes that carry special meaning for the display decoder
//   ROW_IDLE     : row drive pattern selecting row 0
//   COLS_IDLE    : column return pattern with no key pressed
//   decode_col() : {hit, index} for a column pattern with exactly one low bit
// -----------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic [1:0] {
      SCAN        = 2'd0,
      DEB_PRESS   = 2'd1,
      EMIT        = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   // Codes shared with the 7-segment decoder; 4'hD..4'hF render blank.
   localparam logic [3:0] KEY_MINUS   = 4'hB;
   localparam logic [3:0] KEY_A       = 4'hC;
   localparam logic [3:0] KEY_BLANK_D = 4'hD;
   localparam logic [3:0] KEY_BLANK_E = 4'hE;
   localparam logic [3:0] KEY_BLANK_F = 4'hF;

   localparam logic [3:0] ROW_IDLE  = 4'b1110;
   localparam logic [3:0] COLS_IDLE = 4'b1111;

   // Bit 2 flags a single low column, bits 1:0 give its index. Zero or
   // several low columns are treated as "no key" (ghosting / chord).
   function automatic logic [2:0] decode_col(input logic [3:0] cols);
      case (cols)
         4'b1110: return 3'b100;
         4'b1101: return 3'b101;
         4'b1011: return 3'b110;
         4'b0111: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/calc_sync2.sv
// -----------------------------------------------------------------------------
// calc_sync2
// Two-flop synchroniser for a bus of independent asynchronous bits.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, both flops load RST_VAL
//   d       : asynchronous input
//   q       : synchronised output, two clk cycles behind d
// -----------------------------------------------------------------------------
module calc_sync2 #(
   parameter int             W       = 4,
   parameter logic [W-1:0]   RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sync_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= RST_VAL;
         q       <= RST_VAL;
      end else begin
         // stage p0: metastability capture
         sync_p0 <= d;
         // stage p1: resolved output
         q       <= sync_p0;
      end
   end

endmodule

// File: rtl/calc_keypad_encoder.sv
// -----------------------------------------------------------------------------
// calc_keypad_encoder
// Scans a 4x4 active-low key matrix, debounces press and release, and emits
// one 4-bit key code (row*4 + col) per physical press over valid/ready.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   cols_n[3:0]  : column returns, active-low, asynchronous to clk
//   rows_n[3:0]  : one-cold row drive
//   key_code[3:0]: encoded key, held while key_valid is high
//   key_valid    : a code is pending
//   key_ready    : consumer accepts the pending code
//   overflow     : sticky, a confirmed press was dropped while a code pended
//   overflow_clr : synchronous clear of overflow (a simultaneous set wins)
// SCAN_DIV (>= 3) is the dwell per row; DEBOUNCE_CYCLES (>= 2) is the stable
// time needed to confirm a press or a release.
// -----------------------------------------------------------------------------
module calc_keypad_encoder #(
   parameter int SCAN_DIV        = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] cols_n,
   output logic [3:0] rows_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow,
   input  logic       overflow_clr
);

   import calc_pkg::*;

   localparam int DW  = $clog2(SCAN_DIV);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DEB_DONE   = DBW'(DEBOUNCE_CYCLES);

   // Saturating increments: the counters are cleared by the FSM before they
   // could ever reach their limit, but must never wrap if that changes.
   function automatic logic [DW-1:0] dwell_inc(input logic [DW-1:0] v);
      return (v == DWELL_LAST) ? v : v + DW'(1);
   endfunction

   function automatic logic [DBW-1:0] deb_inc(input logic [DBW-1:0] v);
      return (v == DEB_DONE) ? v : v + DBW'(1);
   endfunction

   function automatic logic [3:0] row_drive(input logic [1:0] r);
      return ~(4'b0001 << r);
   endfunction

   state_t         state, state_nx;
   logic [1:0]     row, row_nx;
   logic [DW-1:0]  dwell, dwell_nx;
   logic [DBW-1:0] deb, deb_nx, deb_up;
   logic [3:0]     pat, pat_nx;
   logic [1:0]     col, col_nx;
   logic [3:0]     rows_nx;
   logic [3:0]     code_nx;
   logic           valid_nx;
   logic           ovf_nx;
   logic [3:0]     cols_s;
   logic [2:0]     col_dec;
   logic           xfer;

   // Column returns come from switches: synchronise before any decision.
   calc_sync2 #(
      .W       (4),
      .RST_VAL (COLS_IDLE)
   ) u_cols_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cols_n),
      .q     (cols_s)
   );

   assign col_dec = decode_col(cols_s);
   assign xfer    = key_valid & key_ready;
   assign deb_up  = deb_inc(deb);

   always_comb begin
      state_nx = state;
      row_nx   = row;
      dwell_nx = dwell;
      deb_nx   = deb;
      pat_nx   = pat;
      col_nx   = col;
      rows_nx  = rows_n;
      code_nx  = key_code;
      // A transfer retires the pending code unless EMIT reloads it below.
      valid_nx = key_valid & ~key_ready;
      // Clear first so that an overflow set later in this block wins.
      ovf_nx   = overflow & ~overflow_clr;

      case (state)
         SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_nx = '0;
               deb_nx   = '0;
               if (col_dec[2]) begin
                  pat_nx   = cols_s;
                  col_nx   = col_dec[1:0];
                  state_nx = DEB_PRESS;
               end else begin
                  row_nx  = row + 2'd1;
                  rows_nx = row_drive(row + 2'd1);
               end
            end else begin
               dwell_nx = dwell_inc(dwell);
            end
         end

         DEB_PRESS: begin
            if (cols_s == pat) begin
               if (deb_up == DEB_DONE) begin
                  deb_nx   = '0;
                  state_nx = EMIT;
               end else begin
                  deb_nx = deb_up;
               end
            end else begin
               // Bounce or lift during confirmation: give up, move on.
               deb_nx   = '0;
               dwell_nx = '0;
               row_nx   = row + 2'd1;
               rows_nx  = row_drive(row + 2'd1);
               state_nx = SCAN;
            end
         end

         EMIT: begin
            if (!key_valid || xfer) begin
               code_nx  = {row, col};
               valid_nx = 1'b1;
            end else begin
               ovf_nx = 1'b1;
            end
            deb_nx   = '0;
            state_nx = DEB_RELEASE;
         end

         DEB_RELEASE: begin
            // Holding here until a clean release is what suppresses repeat.
            if (cols_s == COLS_IDLE) begin
               if (deb_up == DEB_DONE) begin
                  deb_nx   = '0;
                  dwell_nx = '0;
                  row_nx   = row + 2'd1;
                  rows_nx  = row_drive(row + 2'd1);
                  state_nx = SCAN;
               end else begin
                  deb_nx = deb_up;
               end
            end else begin
               deb_nx = '0;
            end
         end

         default: begin
            state_nx = SCAN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SCAN;
         row       <= 2'd0;
         dwell     <= '0;
         deb       <= '0;
         pat       <= COLS_IDLE;
         col       <= 2'd0;
         rows_n    <= ROW_IDLE;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nx;
         row       <= row_nx;
         dwell     <= dwell_nx;
         deb       <= deb_nx;
         pat       <= pat_nx;
         col       <= col_nx;
         rows_n    <= rows_nx;
         key_code  <= code_nx;
         key_valid <= valid_nx;
         overflow  <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_calc_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_calc_keypad_encoder
// Bench for calc_keypad_encoder with SCAN_DIV=4, DEBOUNCE_CYCLES=8. A key
// matrix model drives cols_n from rows_n and a 16-bit "pressed" mask; the
// expected code stream is the list of keys pressed, in order.
// -----------------------------------------------------------------------------
module tb_calc_keypad_encoder;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] cols_n;
   logic [3:0] rows_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready = 1'b0;
   logic       overflow;
   logic       overflow_clr = 1'b0;

   logic [15:0] pressed = '0;

   int checks = 0;
   int errors = 0;

   logic [3:0] got[$];

   always #5 clk = ~clk;

   calc_keypad_encoder #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cols_n       (cols_n),
      .rows_n       (rows_n),
      .key_code     (key_code),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   // Key matrix: a pressed key shorts its column to its row when that row is driven low.
   always_comb begin
      cols_n = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!rows_n[r])
            for (int c = 0; c < 4; c++)
               if (pressed[r*4+c]) cols_n[c] = 1'b0;
   end

   // Consumer side: record every transfer; a pending code must not change.
   logic       prev_valid = 1'b0;
   logic       prev_xfer  = 1'b0;
   logic [3:0] prev_code  = 4'h0;

   always @(negedge clk) begin
      if (rst_n && prev_valid && !prev_xfer && key_valid) begin
         checks++;
         if (key_code !== prev_code) begin
            errors++;
            $display("FAIL code_stable: key_code=%h while pending, required %h", key_code, prev_code);
         end
      end
      if (key_valid && key_ready) got.push_back(key_code);
      prev_valid = key_valid;
      prev_xfer  = key_valid && key_ready;
      prev_code  = key_code;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         key_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic hold(input int idx, input int n);
      pressed[idx] = 1'b1;
      cycles(n);
      pressed[idx] = 1'b0;
   endtask

   task automatic test_reset;
      logic [3:0] one_hot;
      logic [3:0] exp_rows;
      rst_n = 1'b0;
      key_ready = 1'b0;
      pressed = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (rows_n !== 4'b1110) begin errors++; $display("FAIL reset_rows: rows_n=%b required 1110", rows_n); end
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: key_valid=%b required 0", key_valid); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: overflow=%b required 0", overflow); end
      checks++;
      if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: key_code=%h required 0", key_code); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5 * SCAN_DIV; i++) begin
         @(negedge clk);
         one_hot  = 4'b0001 << ((i / SCAN_DIV) % 4);
         exp_rows = ~one_hot;
         checks++;
         if (rows_n !== exp_rows) begin
            errors++;
            $display("FAIL scan_rows[%0d]: rows_n=%b required %b", i, rows_n, exp_rows);
         end
      end
   endtask

   task automatic test_clean_press;
      cycles(1);
      key_ready = 1'b1;
      got.delete();
      hold(9, 40);
      cycles(40);
      checks++;
      if (got.size() != 1) begin errors++; $display("FAIL clean_count: %0d codes, required 1", got.size()); end
      else begin
         checks++;
         if (got[0] !== 4'h9) begin errors++; $display("FAIL clean_code: code=%h required 9", got[0]); end
      end
      hold(9, 40);
      cycles(40);
      checks++;
      if (got.size() != 2) begin errors++; $display("FAIL clean_repress_count: %0d codes, required 2", got.size()); end
      else begin
         checks++;
         if (got[1] !== 4'h9) begin errors++; $display("FAIL clean_repress_code: code=%h required 9", got[1]); end
      end
   endtask

   task automatic test_bounce;
      got.delete();
      key_ready = 1'b1;
      pressed[3] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycles(3);
         pressed[3] = ~pressed[3];
      end
      @(negedge clk);
      checks++;
      if (got.size() != 0 || key_valid !== 1'b0) begin
         errors++;
         $display("FAIL bounce_early: %0d codes key_valid=%b during bounce, required none", got.size(), key_valid);
      end
      cycles(40);
      pressed[3] = 1'b0;
      cycles(40);
      checks++;
      if (got.size() != 1) begin errors++; $display("FAIL bounce_count: %0d codes, required 1", got.size()); end
      else begin
         checks++;
         if (got[0] !== 4'h3) begin errors++; $display("FAIL bounce_code: code=%h required 3", got[0]); end
      end
   endtask

   task automatic test_backpressure;
      cycles(1);
      key_ready = 1'b0;
      got.delete();
      hold(5, 45);
      cycles(30);
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b1 || key_code !== 4'h5) begin
         errors++;
         $display("FAIL bp_first: valid=%b code=%h, required 1 and 5", key_valid, key_code);
      end
      hold(6, 45);
      cycles(30);
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b1 || key_code !== 4'h5) begin
         errors++;
         $display("FAIL bp_hold: valid=%b code=%h, required 1 and 5", key_valid, key_code);
      end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: overflow=%b required 1", overflow); end
      @(posedge clk);
      #1 key_ready = 1'b1;
      @(posedge clk);
      #1 key_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: key_valid=%b required 0", key_valid); end
      checks++;
      if (got.size() != 1 || got[0] !== 4'h5) begin
         errors++;
         $display("FAIL bp_transfer: %0d transfers, required exactly one of code 5", got.size());
      end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky: overflow=%b required 1", overflow); end
      @(posedge clk);
      #1 overflow_clr = 1'b1;
      @(posedge clk);
      #1 overflow_clr = 1'b0;
      @(negedge clk);
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL bp_clear: overflow=%b required 0", overflow); end
   endtask

   task automatic test_two_columns;
      logic [3:0] seen;
      bit         hit;
      cycles(1);
      key_ready = 1'b1;
      got.delete();
      seen = '0;
      pressed[4] = 1'b1;
      pressed[5] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         seen = seen | ~rows_n;
      end
      checks++;
      if (got.size() != 0) begin errors++; $display("FAIL chord_code: %0d codes, required 0", got.size()); end
      checks++;
      if (seen !== 4'hF) begin errors++; $display("FAIL chord_scan: rows visited=%b required 1111", seen); end
      pressed = '0;
      cycles(20);

      // Reset while waiting for the release of key 14 (row 3, col 2).
      key_ready = 1'b0;
      pressed[14] = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 80 && !hit; i++) begin
         @(negedge clk);
         if (key_valid) hit = 1'b1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL release_wait: key_valid=0 after 80 cycles, required 1"); end
      cycles(3);
      checks++;
      if (rows_n !== 4'b0111 || key_code !== 4'hE) begin
         errors++;
         $display("FAIL release_pre: rows_n=%b code=%h, required 0111 and e", rows_n, key_code);
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if (rows_n !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: rows_n=%b valid=%b code=%h ovf=%b, required 1110 0 0 0",
                  rows_n, key_valid, key_code, overflow);
      end
      pressed = '0;
      cycles(3);
      rst_n = 1'b1;
      cycles(5);
   endtask

   task automatic test_random;
      logic [3:0] exp_q[$];
      int         idx;
      got.delete();
      for (int p = 0; p < 6; p++) begin
         idx = int'($urandom_range(0, 15));
         exp_q.push_back(4'(idx));
         pressed[idx] = 1'b1;
         rand_cycles(int'($urandom_range(45, 70)));
         pressed[idx] = 1'b0;
         rand_cycles(int'($urandom_range(25, 40)));
      end
      key_ready = 1'b1;
      cycles(10);
      checks++;
      if (got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: %0d codes, required %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_code[%0d]: code=%h required %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: overflow=%b required 0", overflow); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_backpressure();
      test_two_columns();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

endmodule
